heap_array_arbiter: RTL and testbench

Shared heap-array service for the zero machine. Multiple requesters issue array operations (allocate, free, push, pop) against one heap of fixed-size array areas, and this block arbitrates among them round-robin. It maintains per-array sizes, allocation flags and the freed-array LIFO stack, and returns one response per accepted request. It replaces ad-hoc per-program array bookkeeping with a single sequenced owner of the heap.

---
 rtl/heap_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/heap_array_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_heap_array_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared types for the heap-array service:
// op and status codes, FSM states and a width helper.
package heap_pkg;

    typedef enum logic [1:0] {
        OpAlloc = 2'd0,
        OpFree  = 2'd1,
        OpPush  = 2'd2,
        OpPop   = 2'd3
    } heapOp_t;

    typedef enum logic [1:0] {
        StOk       = 2'd0,
        StFull     = 2'd1,
        StEmpty    = 2'd2,
        StBadArray = 2'd3
    } heapStatus_t;

    typedef enum logic [1:0] {
        FsmIdle = 2'd0,
        FsmExec = 2'd1,
        FsmResp = 2'd2
    } fsmState_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the
// last one granted; the pointer only moves on an accepted grant.
module rr_arbiter
    import heap_pkg::*;
#(
    parameter int NRequesters = 2,
    localparam int GW = idxWidth(NRequesters)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NRequesters-1:0] valid,
    input  logic                   advance,
    output logic [NRequesters-1:0] grant,
    output logic [GW-1:0]          grantIdx
);

    logic [GW-1:0] ptr;
    logic          found;
    int            cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NRequesters; k++) begin
            cand = (int'(ptr) + k) % NRequesters;
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = GW'(cand);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= GW'(NRequesters - 1);
        end else if (advance && found) begin
            ptr <= grantIdx;
        end
    end

endmodule

// File: rtl/heap_array_arbiter.sv
// Shared heap-array service: arbitrates requesters and owns the array
// sizes, allocation flags, freed-index stack and the heap RAM.
module heap_array_arbiter
    import heap_pkg::*;
#(
    parameter int NRequesters        = 2,
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 4,
    parameter int NArea              = 3
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NRequesters-1:0]                    req_valid,
    output logic [NRequesters-1:0]                    req_ready,
    input  logic [2*NRequesters-1:0]                  req_op,
    input  logic [MemoryElementWidth*NRequesters-1:0] req_array,
    input  logic [MemoryElementWidth*NRequesters-1:0] req_data,
    output logic [NRequesters-1:0]                    rsp_valid,
    output logic [MemoryElementWidth-1:0]             rsp_data,
    output logic [1:0]                                rsp_status,
    output logic [MemoryElementWidth-1:0]             in_use
);

    localparam int W     = MemoryElementWidth;
    localparam int Depth = NArrays * NArea;
    localparam int AddrW = idxWidth(Depth);
    localparam int IdxW  = idxWidth(NArrays);
    localparam int GW    = idxWidth(NRequesters);

    localparam logic [W-1:0]  NArraysW = W'(NArrays);
    localparam logic [W-1:0]  NAreaW   = W'(NArea);
    localparam logic [IdxW:0] NArraysC = (IdxW + 1)'(NArrays);

    fsmState_t state;
    fsmState_t nextState;

    logic [NRequesters-1:0] grant;
    logic [GW-1:0]          grantIdx;
    logic                   accept;

    logic [GW-1:0] curReq;
    heapOp_t       curOp;
    logic [W-1:0]  curArray;
    logic [W-1:0]  curData;

    logic [W-1:0]      size [NArrays];
    logic [NArrays-1:0] allocated;
    logic [IdxW-1:0]   freedStack [NArrays];
    logic [IdxW:0]     freedCount;
    logic [IdxW:0]     highWater;
    logic [W-1:0]      inUse;

    logic [W-1:0] rspDataQ;
    heapStatus_t  rspStatusQ;
    logic         popPending;

    logic [IdxW-1:0]  idx;
    logic [IdxW-1:0]  stackTop;
    logic [IdxW-1:0]  allocIdx;
    logic [W-1:0]     curSize;
    logic             arrayOk;
    logic             reuse;
    logic [AddrW-1:0] baseAddr;
    logic [AddrW-1:0] slotAddr;
    heapStatus_t      exStatus;
    logic [W-1:0]     exData;

    logic [W-1:0]     heap [Depth];
    logic [W-1:0]     ramQ;
    logic             ramWe;
    logic             ramRe;
    logic [AddrW-1:0] ramAddr;

    assign accept = (state == FsmIdle) && (|req_valid);

    rr_arbiter #(
        .NRequesters(NRequesters)
    ) arb (
        .clock    (clock),
        .reset    (reset),
        .valid    (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    // Gated by reset so no acceptance is offered while reset is held.
    assign req_ready = (accept && reset) ? grant : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FsmIdle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            FsmIdle: if (accept) nextState = FsmExec;
            FsmExec: nextState = FsmResp;
            FsmResp: nextState = FsmIdle;
            default: nextState = FsmIdle;
        endcase
    end

    always_comb begin
        idx      = curArray[IdxW-1:0];
        curSize  = size[idx];
        arrayOk  = (curArray < NArraysW) && allocated[idx];
        reuse    = (freedCount != '0);
        stackTop = freedCount[IdxW-1:0] - IdxW'(1);
        allocIdx = reuse ? freedStack[stackTop] : highWater[IdxW-1:0];
        baseAddr = AddrW'(idx) * AddrW'(NArea);
        slotAddr = baseAddr + AddrW'(curSize);
        exStatus = StOk;
        exData   = '0;
        ramWe    = 1'b0;
        ramRe    = 1'b0;
        ramAddr  = slotAddr;
        unique case (curOp)
            OpAlloc: begin
                if (reuse || (highWater < NArraysC)) begin
                    exData = W'(allocIdx);
                end else begin
                    exStatus = StFull;
                end
            end
            OpFree: begin
                if (!arrayOk) exStatus = StBadArray;
            end
            OpPush: begin
                if (!arrayOk) begin
                    exStatus = StBadArray;
                end else if (curSize == NAreaW) begin
                    exStatus = StFull;
                end else begin
                    ramWe  = (state == FsmExec);
                    exData = curSize + W'(1);
                end
            end
            OpPop: begin
                if (!arrayOk) begin
                    exStatus = StBadArray;
                end else if (curSize == '0) begin
                    exStatus = StEmpty;
                end else begin
                    ramRe   = (state == FsmExec);
                    ramAddr = slotAddr - AddrW'(1);
                end
            end
            default: exStatus = StBadArray;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            curReq     <= '0;
            curOp      <= OpAlloc;
            curArray   <= '0;
            curData    <= '0;
            allocated  <= '0;
            freedCount <= '0;
            highWater  <= '0;
            inUse      <= '0;
            rspDataQ   <= '0;
            rspStatusQ <= StOk;
            popPending <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                size[i]       <= '0;
                freedStack[i] <= '0;
            end
        end else begin
            unique case (state)
                FsmIdle: begin
                    if (accept) begin
                        curReq   <= grantIdx;
                        curOp    <= heapOp_t'(req_op[grantIdx*2 +: 2]);
                        curArray <= req_array[grantIdx*W +: W];
                        curData  <= req_data[grantIdx*W +: W];
                    end
                end
                FsmExec: begin
                    rspStatusQ <= exStatus;
                    rspDataQ   <= exData;
                    popPending <= (curOp == OpPop) && (exStatus == StOk);
                    if (exStatus == StOk) begin
                        unique case (curOp)
                            OpAlloc: begin
                                if (reuse) begin
                                    freedCount <= freedCount - 1'b1;
                                end else begin
                                    highWater <= highWater + 1'b1;
                                end
                                size[allocIdx]      <= '0;
                                allocated[allocIdx] <= 1'b1;
                                inUse               <= inUse + W'(1);
                            end
                            OpFree: begin
                                freedStack[freedCount[IdxW-1:0]] <= idx;
                                freedCount     <= freedCount + 1'b1;
                                allocated[idx] <= 1'b0;
                                inUse          <= inUse - W'(1);
                            end
                            OpPush: size[idx] <= curSize + W'(1);
                            OpPop:  size[idx] <= curSize - W'(1);
                            default: ;
                        endcase
                    end
                end
                FsmResp: begin
                    if (popPending) rspDataQ <= ramQ;
                end
                default: ;
            endcase
        end
    end

    // Heap contents survive reset; only the bookkeeping is cleared.
    always_ff @(posedge clock) begin
        if (ramWe) heap[ramAddr] <= curData;
        if (ramRe) ramQ <= heap[ramAddr];
    end

    always_comb begin
        rsp_valid = '0;
        if (state == FsmResp) rsp_valid[curReq] = 1'b1;
    end

    assign rsp_data   = ((state == FsmResp) && popPending) ? ramQ : rspDataQ;
    assign rsp_status = rspStatusQ;
    assign in_use     = inUse;

endmodule

// File: tb/tb_heap_array_arbiter.sv
// Directed vector bench for heap_array_arbiter.
// Table of single operations plus arbitration and reset sequences.
module tb_heap_array_arbiter;

    localparam int N = 2;
    localparam int W = 12;

    localparam logic [1:0] ALLOC = 2'd0;
    localparam logic [1:0] FREE  = 2'd1;
    localparam logic [1:0] PUSH  = 2'd2;
    localparam logic [1:0] POP   = 2'd3;

    localparam logic [1:0] OK    = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] EMPTY = 2'd2;
    localparam logic [1:0] BAD   = 2'd3;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_array;
    logic [W*N-1:0] req_data;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_status;
    logic [W-1:0]   in_use;

    int nVec = 0;
    int nBad = 0;

    typedef struct {
        int         r;
        logic [1:0] op;
        logic [W-1:0] arr;
        logic [W-1:0] dat;
        logic [1:0] st;
        logic [W-1:0] rd;
        logic [W-1:0] iu;
    } vec_t;

    vec_t tbl[$];

    heap_array_arbiter #(
        .NRequesters        (N),
        .MemoryElementWidth (W),
        .NArrays            (4),
        .NArea              (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_array  (req_array),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .in_use     (in_use)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic doOp(input int r, input logic [1:0] op,
                        input logic [W-1:0] arr, input logic [W-1:0] dat,
                        input logic [1:0] st, input logic [W-1:0] rd,
                        input logic [W-1:0] iu, input string tag);
        int cyc;
        @(negedge clock);
        req_op[2*r +: 2]    = op;
        req_array[W*r +: W] = arr;
        req_data[W*r +: W]  = dat;
        req_valid[r]        = 1'b1;
        #1;
        cyc = 0;
        while (req_ready[r] !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " grant"}, 32'(cyc < 20), 32'd1);
        if (cyc >= 20) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clock);
        #1 req_valid[r] = 1'b0;
        @(negedge clock);
        check({tag, " early rsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clock);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
        check({tag, " status"}, 32'(rsp_status), 32'(st));
        check({tag, " data"}, 32'(rsp_data), 32'(rd));
        check({tag, " in_use"}, 32'(in_use), 32'(iu));
        @(negedge clock);
        check({tag, " held data"}, 32'(rsp_data), 32'(rd));
        check({tag, " held status"}, 32'(rsp_status), 32'(st));
    endtask

    logic [N-1:0] gnt [4];
    logic [N-1:0] rvs [4];
    logic [W-1:0] rds [4];
    logic [N-1:0] rdy;
    logic [N-1:0] rv0;
    logic [W-1:0] d0;
    logic         seen;

    initial begin
        // order
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd0,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd1,   OK,    12'd1,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd2,   OK,    12'd2,   12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd2,   12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd1,   12'd1});
        // bounds
        tbl.push_back('{0, PUSH,  12'd0, 12'd10,  OK,    12'd1,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd11,  OK,    12'd2,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd12,  OK,    12'd3,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd13,  FULL,  12'd0,   12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd12,  12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd11,  12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd10,  12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   EMPTY, 12'd0,   12'd1});
        tbl.push_back('{0, PUSH,  12'd0, 12'd5,   OK,    12'd1,   12'd1});
        tbl.push_back('{0, POP,   12'd0, 12'd0,   OK,    12'd5,   12'd1});
        // exhaustion and LIFO reuse
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd1,   12'd2});
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd2,   12'd3});
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd3,   12'd4});
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   FULL,  12'd0,   12'd4});
        tbl.push_back('{0, FREE,  12'd2, 12'd0,   OK,    12'd0,   12'd3});
        tbl.push_back('{0, FREE,  12'd0, 12'd0,   OK,    12'd0,   12'd2});
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd0,   12'd3});
        tbl.push_back('{0, ALLOC, 12'd0, 12'd0,   OK,    12'd2,   12'd4});
        // invalid targets
        tbl.push_back('{1, FREE,  12'd1, 12'd0,   OK,    12'd0,   12'd3});
        tbl.push_back('{1, FREE,  12'd1, 12'd0,   BAD,   12'd0,   12'd3});
        tbl.push_back('{0, PUSH,  12'd7, 12'd9,   BAD,   12'd0,   12'd3});
        tbl.push_back('{0, PUSH,  12'hfff, 12'd9, BAD,   12'd0,   12'd3});
        tbl.push_back('{1, POP,   12'd1, 12'd0,   BAD,   12'd0,   12'd3});
        tbl.push_back('{0, POP,   12'd3, 12'd0,   EMPTY, 12'd0,   12'd3});
        tbl.push_back('{0, PUSH,  12'd3, 12'h5a5, OK,    12'd1,   12'd3});
        tbl.push_back('{1, POP,   12'd3, 12'd0,   OK,    12'h5a5, 12'd3});

        reset     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_array = '0;
        req_data  = '0;
        repeat (3) @(negedge clock);
        req_valid = 2'b11;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_status", 32'(rsp_status), 32'd0);
        check("reset in_use", 32'(in_use), 32'd0);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            doOp(tbl[i].r, tbl[i].op, tbl[i].arr, tbl[i].dat,
                 tbl[i].st, tbl[i].rd, tbl[i].iu, $sformatf("v%0d", i));
        end

        // arbitration with both requesters holding ALLOC
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gnt[i] = '0;
            rvs[i] = '0;
            rds[i] = '0;
        end
        @(negedge clock);
        req_op    = {ALLOC, ALLOC};
        req_array = '0;
        req_valid = 2'b11;
        #1;
        begin
            int ng;
            int nr;
            int cyc;
            ng  = 0;
            nr  = 0;
            cyc = 0;
            while (nr < 4 && cyc < 40) begin
                rdy = req_ready;
                rv0 = rsp_valid;
                d0  = rsp_data;
                if (rv0 != '0 && nr < 4) begin
                    rvs[nr] = rv0;
                    rds[nr] = d0;
                    nr++;
                end
                if (rdy != '0 && ng < 4) begin
                    gnt[ng] = rdy;
                    ng++;
                    if (ng == 4) begin
                        @(posedge clock);
                        #1 req_valid = '0;
                    end
                end
                @(negedge clock);
                cyc++;
            end
            check("arb response count", 32'(nr), 32'd4);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb grant %0d", i), 32'(gnt[i]), 32'(1 << (i % 2)));
            check($sformatf("arb rsp %0d", i), 32'(rvs[i]), 32'(1 << (i % 2)));
            check($sformatf("arb index %0d", i), 32'(rds[i]), 32'(i));
        end
        check("arb in_use", 32'(in_use), 32'd4);

        // reset during EXEC of a PUSH
        @(negedge clock);
        req_op[1:0]    = PUSH;
        req_array[W-1:0] = 12'd0;
        req_data[W-1:0]  = 12'd7;
        req_valid      = 2'b01;
        #1;
        begin
            int cyc;
            cyc = 0;
            while (req_ready[0] !== 1'b1 && cyc < 20) begin
                @(negedge clock);
                cyc++;
            end
            check("mid-reset grant", 32'(cyc < 20), 32'd1);
        end
        @(posedge clock);
        #1 req_valid = '0;
        #2 reset = 1'b0;
        req_op[3:2]  = ALLOC;
        req_valid    = 2'b10;
        #1;
        check("mid-reset req_ready", 32'(req_ready), 32'd0);
        check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-reset rsp_data", 32'(rsp_data), 32'd0);
        check("mid-reset rsp_status", 32'(rsp_status), 32'd0);
        check("mid-reset in_use", 32'(in_use), 32'd0);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            seen = seen | (|rsp_valid);
        end
        check("mid-reset no response", 32'(seen), 32'd0);
        doOp(0, ALLOC, 12'd0, 12'd0, OK, 12'd0, 12'd1, "post-reset alloc");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
